// File: rtl/program_loader.sv
// Loads a byte stream (count, big-endian words, XOR checksum) into instruction memory and holds the CPU until verified.
// Three cycles per word with a continuous stream; byte_valid may stall any byte-accepting state indefinitely.
module program_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        instr_write_enable,
    output logic [7:0]  instr_address,
    output logic [15:0] instr_data,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_HIGH,
        S_LOW,
        S_WRITE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [8:0]  remaining;
    logic [7:0]  checksum;
    logic        accept;
    logic        begin_load;

    assign accept = byte_ready & byte_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt          = state;
        byte_ready         = 1'b0;
        instr_write_enable = 1'b0;
        cpu_hold           = 1'b1;
        begin_load         = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    begin_load = 1'b1;
                    state_nxt  = S_COUNT;
                end
            end
            S_COUNT: begin
                byte_ready = 1'b1;
                if (byte_valid) state_nxt = S_HIGH;
            end
            S_HIGH: begin
                byte_ready = 1'b1;
                if (byte_valid) state_nxt = S_LOW;
            end
            S_LOW: begin
                byte_ready = 1'b1;
                if (byte_valid) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                instr_write_enable = 1'b1;
                // remaining is decremented on this edge, so 1 here means the last word
                state_nxt = (remaining == 9'd1) ? S_CHECK : S_HIGH;
            end
            S_CHECK: begin
                byte_ready = 1'b1;
                if (byte_valid) state_nxt = S_DONE;
            end
            S_DONE: begin
                cpu_hold = load_error;
                if (start) begin
                    begin_load = 1'b1;
                    state_nxt  = S_COUNT;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            remaining     <= 9'd0;
            checksum      <= 8'h00;
            instr_address <= 8'h00;
            instr_data    <= 16'h0000;
            load_done     <= 1'b0;
            load_error    <= 1'b0;
        end else begin
            if (begin_load) begin
                instr_address <= 8'h00;
                checksum      <= 8'h00;
                load_done     <= 1'b0;
                load_error    <= 1'b0;
            end
            if (accept) begin
                case (state)
                    S_COUNT: begin
                        remaining <= (byte_data == 8'h00) ? 9'd256 : {1'b0, byte_data};
                        checksum  <= checksum ^ byte_data;
                    end
                    S_HIGH: begin
                        instr_data[15:8] <= byte_data;
                        checksum         <= checksum ^ byte_data;
                    end
                    S_LOW: begin
                        instr_data[7:0] <= byte_data;
                        checksum        <= checksum ^ byte_data;
                    end
                    S_CHECK: begin
                        load_done  <= (byte_data == checksum);
                        load_error <= (byte_data != checksum);
                    end
                    default: ;
                endcase
            end
            if (state == S_WRITE) begin
                instr_address <= instr_address + 8'd1;
                remaining     <= remaining - 9'd1;
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: stimulus pushes expected memory writes, a monitor pops and compares them.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        instr_write_enable;
    logic [7:0]  instr_address;
    logic [15:0] instr_data;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;

    program_loader dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .byte_valid(byte_valid),
        .byte_data(byte_data),
        .byte_ready(byte_ready),
        .instr_write_enable(instr_write_enable),
        .instr_address(instr_address),
        .instr_data(instr_data),
        .cpu_hold(cpu_hold),
        .load_done(load_done),
        .load_error(load_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t         exp_wr[$];
    logic [15:0] prog[256];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          gap_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the head of the expected-write queue.
    initial begin
        logic        pw;
        logic [7:0]  pa;
        logic [15:0] pd;
        wr_t         e;
        pw = 1'b0;
        pa = 8'h00;
        pd = 16'h0000;
        forever begin
            @(negedge clk);
            if (pw && reset)
                check("post_write_incr", 32'({instr_address, instr_data}), 32'({pa + 8'd1, pd}));
            if (instr_write_enable) begin
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                             instr_address, instr_data);
                end else begin
                    e = exp_wr.pop_front();
                    check("write", 32'({instr_address, instr_data}), 32'(e));
                end
            end
            pw = instr_write_enable;
            pa = instr_address;
            pd = instr_data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] b);
        int n;
        int g;
        g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
        repeat (g) begin
            byte_valid = 1'b0;
            byte_data  = 8'($urandom);
            @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        while (!byte_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!byte_ready) begin
            checks++;
            errors++;
            $display("FAIL byte_ready_timeout: got 0, expected 1 within 200 cycles");
        end
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Reference: N words at addresses 0..N-1, checksum = XOR of count and all data bytes.
    task automatic do_load(input int n, input bit force_cs, input logic [7:0] cs_val, input bit glitch);
        logic [7:0] cnt;
        logic [7:0] x;
        logic [7:0] cs;
        bit         good;
        int         s0;
        cnt = 8'(n);
        x   = cnt;
        for (int i = 0; i < n; i++) begin
            exp_wr.push_back({8'(i), prog[i]});
            x = x ^ prog[i][15:8] ^ prog[i][7:0];
        end
        cs   = force_cs ? cs_val : x;
        good = (cs == x);
        pulse_start();
        check("ready_after_start", 32'(byte_ready), 32'd1);
        s0 = cyc;
        send(cnt);
        if (glitch) begin
            byte_valid = 1'b0;
            @(negedge clk);
            pulse_start();
            check("start_ignored_in_high", 32'({byte_ready, instr_address}), 32'({1'b1, 8'h00}));
        end
        for (int i = 0; i < n; i++) begin
            send(prog[i][15:8]);
            send(prog[i][7:0]);
        end
        send(cs);
        byte_valid = 1'b0;
        check("status", 32'({load_done, load_error, cpu_hold, byte_ready}),
              32'({good, !good, !good, 1'b0}));
        check("writes_all_seen", 32'(exp_wr.size()), 32'd0);
        if (gap_mode == 0 && !glitch)
            check("load_latency", 32'(cyc - s0), 32'(3 * n + 2));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready_we"}, 32'({byte_ready, instr_write_enable}), 32'd0);
        check({tag, "_addr_data"}, 32'({instr_address, instr_data}), 32'd0);
        check({tag, "_status"}, 32'({cpu_hold, load_done, load_error}), 32'({1'b1, 1'b0, 1'b0}));
    endtask

    initial begin
        int n;
        #1;
        check_reset_values("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("idle_ready", 32'({byte_ready, cpu_hold}), 32'({1'b0, 1'b1}));

        // single word, good checksum
        gap_mode = 0;
        prog[0] = 16'h1234;
        do_load(1, 1'b1, 8'h27, 1'b0);

        // three words with byte_valid toggling
        gap_mode = 1;
        prog[0] = 16'hA001;
        prog[1] = 16'hB002;
        prog[2] = 16'hC003;
        do_load(3, 1'b0, 8'h00, 1'b0);

        // bad checksum
        gap_mode = 0;
        prog[0] = 16'h1234;
        do_load(1, 1'b1, 8'h00, 1'b0);

        // full memory, count byte 0
        for (int i = 0; i < 256; i++) prog[i] = 16'(i * 257);
        do_load(256, 1'b0, 8'h00, 1'b0);
        check("full_wrap_addr", 32'(instr_address), 32'd0);

        // reset mid-load after the second data byte
        prog[0] = 16'h5A5A;
        exp_wr.push_back({8'h00, prog[0]});
        pulse_start();
        send(8'h03);
        send(prog[0][15:8]);
        send(prog[0][7:0]);
        #1;
        reset = 1'b0;
        byte_valid = 1'b0;
        #1;
        check_reset_values("abort");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        check("abort_no_pending_writes", 32'(exp_wr.size()), 32'd0);
        @(negedge clk);

        // fresh load with start pulsed during HIGH
        gap_mode = 2;
        for (int i = 0; i < 3; i++) prog[i] = 16'($urandom);
        do_load(3, 1'b0, 8'h00, 1'b1);

        // randomized loads, some with corrupted checksum
        for (int t = 0; t < 8; t++) begin
            n = int'($urandom_range(1, 20));
            for (int i = 0; i < n; i++) prog[i] = 16'($urandom);
            gap_mode = int'($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0)
                do_load(n, 1'b1, 8'($urandom), 1'b0);
            else
                do_load(n, 1'b0, 8'h00, 1'b0);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
